pe_vec_acc: RTL

PE_VEC_ACC -- requirements
Module: pe_vec_acc

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_sat_round.sv | 39 +++
 rtl/pe_vec_acc.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared encodings, state type and default widths for the PE vector accumulator
package pe_pkg;

  localparam logic PE_MODE_MAC = 1'b0;
  localparam logic PE_MODE_MAX = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pe_state_t;

  localparam int PE_LANES  = 4;
  localparam int PE_DATA_W = 16;
  localparam int PE_FRAC   = 13;
  localparam int PE_PSUM_W = 16;
  localparam int PE_ACC_W  = 40;
  localparam int PE_CNT_W  = 8;

endpackage

// File: rtl/pe_sat_round.sv
// rtl/pe_sat_round.sv - round-half-up fixed-point shift followed by signed saturation with clip flag
module pe_sat_round
  import pe_pkg::*;
#(
  parameter int ACC_W  = PE_ACC_W,
  parameter int FRAC   = PE_FRAC,
  parameter int PSUM_W = PE_PSUM_W
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic                     round_en,
  output logic signed [PSUM_W-1:0] res,
  output logic                     sat
);

  // One extra headroom bit so adding the half-LSB can never wrap.
  localparam logic signed [ACC_W:0] HALF  = {{(ACC_W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-PSUM_W){1'b0}}, {(PSUM_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-PSUM_W){1'b1}}, {(PSUM_W-1){1'b0}}};

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] shifted;

  // Optional rounding shift, then clamp into the PSUM_W signed range.
  always_comb begin
    ext     = {acc_in[ACC_W-1], acc_in};
    shifted = round_en ? ((ext + HALF) >>> FRAC) : ext;
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      res = MAX_V[PSUM_W-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      res = MIN_V[PSUM_W-1:0];
      sat = 1'b1;
    end else begin
      res = shifted[PSUM_W-1:0];
    end
  end

endmodule

// File: rtl/pe_vec_acc.sv
// rtl/pe_vec_acc.sv - multi-lane MAC / MAX-pool processing element with group accumulation
module pe_vec_acc
  import pe_pkg::*;
#(
  parameter int LANES  = PE_LANES,
  parameter int DATA_W = PE_DATA_W,
  parameter int FRAC   = PE_FRAC,
  parameter int PSUM_W = PE_PSUM_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int CNT_W  = PE_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CNT_W-1:0]          acc_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   ifm,
  input  logic [LANES*DATA_W-1:0]   wgt,
  input  logic signed [PSUM_W-1:0]  psum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [PSUM_W-1:0]  psum_out,
  output logic                      sat_flag
);

  localparam int PROD_W = 2 * DATA_W;

  logic             advance, beat, first, last, cur_mode;
  logic [CNT_W-1:0] len_eff, cnt, len_r;
  logic             mode_r;
  pe_state_t        state;

  logic signed [DATA_W-1:0] ifm_l [LANES];
  logic signed [DATA_W-1:0] wgt_l [LANES];
  logic signed [PROD_W-1:0] lane_val [LANES];

  logic                     s1_valid, s1_first, s1_last, s1_mode;
  logic signed [PSUM_W-1:0] s1_psum;
  logic signed [PROD_W-1:0] s1_lane [LANES];

  logic signed [ACC_W-1:0]  acc, acc_next, lane_sum, lane_max, lane_ext, psum_ext, base;
  logic                     done, done_mode;
  logic signed [PSUM_W-1:0] sr_res;
  logic                     sr_sat;

  // A pending, unconsumed result stalls the whole pipe.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign beat     = in_valid && advance;
  assign len_eff  = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign first    = (state == ST_IDLE);
  assign cur_mode = first ? mode : mode_r;
  assign last     = first ? (len_eff == CNT_W'(1)) : (cnt == len_r - CNT_W'(1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign ifm_l[g] = ifm[g*DATA_W +: DATA_W];
    assign wgt_l[g] = wgt[g*DATA_W +: DATA_W];
  end

  // Group framing: latch mode/length on the first beat, count beats until the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      len_r  <= '0;
      mode_r <= PE_MODE_MAC;
    end else if (beat) begin
      if (first) begin
        mode_r <= mode;
        len_r  <= len_eff;
      end
      if (last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= ST_ACC;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  // Per-lane operand: full-precision product for MAC, sign-extended ifm for MAX.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (cur_mode == PE_MODE_MAX) lane_val[i] = {{DATA_W{ifm_l[i][DATA_W-1]}}, ifm_l[i]};
      else                         lane_val[i] = ifm_l[i] * wgt_l[i];
    end
  end

  // Stage 1: register lane operands together with the group framing of the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= PE_MODE_MAC;
      s1_psum  <= '0;
      for (int i = 0; i < LANES; i++) s1_lane[i] <= '0;
    end else if (advance) begin
      s1_valid <= beat;
      if (beat) begin
        s1_first <= first;
        s1_last  <= last;
        s1_mode  <= cur_mode;
        s1_psum  <= psum_in;
        for (int i = 0; i < LANES; i++) s1_lane[i] <= lane_val[i];
      end
    end
  end

  // Lane reduction and accumulator update; the first beat reseeds from psum so groups never mix.
  always_comb begin
    lane_sum = '0;
    lane_ext = '0;
    lane_max = {{(ACC_W-PROD_W){s1_lane[0][PROD_W-1]}}, s1_lane[0]};
    for (int i = 0; i < LANES; i++) begin
      lane_ext = {{(ACC_W-PROD_W){s1_lane[i][PROD_W-1]}}, s1_lane[i]};
      lane_sum = lane_sum + lane_ext;
      if (lane_ext > lane_max) lane_max = lane_ext;
    end
    psum_ext = {{(ACC_W-PSUM_W){s1_psum[PSUM_W-1]}}, s1_psum};
    if (s1_first) base = (s1_mode == PE_MODE_MAC) ? (psum_ext <<< FRAC) : psum_ext;
    else          base = acc;
    if (s1_mode == PE_MODE_MAC) acc_next = base + lane_sum;
    else                        acc_next = (lane_max > base) ? lane_max : base;
  end

  // Stage 2: accumulator and a one-cycle "group complete" marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      done      <= 1'b0;
      done_mode <= PE_MODE_MAC;
    end else if (advance) begin
      done <= s1_valid && s1_last;
      if (s1_valid) begin
        acc       <= acc_next;
        done_mode <= s1_mode;
      end
    end
  end

  pe_sat_round #(
    .ACC_W  (ACC_W),
    .FRAC   (FRAC),
    .PSUM_W (PSUM_W)
  ) u_sat_round (
    .acc_in   (acc),
    .round_en (done_mode == PE_MODE_MAC),
    .res      (sr_res),
    .sat      (sr_sat)
  );

  // Output register: holds while stalled, otherwise loads the finished group or clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      psum_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (advance) begin
      out_valid <= done;
      psum_out  <= done ? sr_res : '0;
      sat_flag  <= done && sr_sat;
    end
  end

endmodule
